// File: rtl/ysyx_040066_lsu_pkg.sv
// Shared types and helpers for the MEM-stage load unit.
// Holds size codes, the meta/resp bundles and field extraction.
package ysyx_040066_lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // Per-load bookkeeping kept until its beat returns.
    // 'sgn' is the signed/unsigned extension mode.
    typedef struct packed {
        logic [2:0] offset;
        logic [1:0] size;
        logic       sgn;
    } meta_t;

    typedef struct packed {
        logic [63:0] data;
        logic        err;
    } resp_t;

    function automatic logic lsu_aligned(
        input logic [2:0] lo,
        input logic [1:0] size
    );
        logic ok;
        unique case (size)
            SZ_B: ok = 1'b1;
            SZ_H: ok = (lo[0] == 1'b0);
            SZ_W: ok = (lo[1:0] == 2'b00);
            SZ_D: ok = (lo == 3'b000);
        endcase
        return ok;
    endfunction

    // Shift the addressed field down to bit 0, then
    // zero- or sign-extend it to 64 bits.
    function automatic logic [63:0] lsu_extract(
        input logic [63:0] beat,
        input meta_t       m
    );
        logic [63:0] sh;
        logic [63:0] r;
        sh = beat >> {m.offset, 3'b000};
        unique case (m.size)
            SZ_B: r = m.sgn ? {{56{sh[7]}}, sh[7:0]}
                            : {56'b0, sh[7:0]};
            SZ_H: r = m.sgn ? {{48{sh[15]}}, sh[15:0]}
                            : {48'b0, sh[15:0]};
            SZ_W: r = m.sgn ? {{32{sh[31]}}, sh[31:0]}
                            : {32'b0, sh[31:0]};
            SZ_D: r = sh;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ysyx_040066_sync_fifo.sv
// Synchronous FIFO with combinational head and extra-bit pointers.
// Ports: clk, rst (sync, low), push/push_data, pop, full, empty, head.
module ysyx_040066_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      wptr;
    logic [PW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (wptr == rptr);
    assign full  = (wptr[PW] != rptr[PW]) &&
                   (wptr[PW-1:0] == rptr[PW-1:0]);

    // A pop frees the slot the same cycle, so push
    // into a full FIFO is fine when paired with a pop.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign head = mem[rptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/ysyx_040066_lsu_rd.sv
// In-order load unit: issues 64-bit beats, extracts/extends fields.
// Ports: req_* in, resp_* out, mem_* backing read port, idle.
module ysyx_040066_lsu_rd
    import ysyx_040066_lsu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic [1:0]    req_size,
    input  logic          req_signed,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [63:0]   resp_data,
    output logic          resp_err,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_resp_valid,
    input  logic [63:0]   mem_rdata,
    input  logic          mem_resp_err,
    output logic          idle
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] credit;
    logic [CW-1:0] inflight;

    logic  aligned;
    logic  slot_free;
    logic  acc;
    logic  acc_al;
    logic  acc_mis;
    logic  beat;
    logic  rsp_pop;

    meta_t meta_in;
    meta_t meta_head;
    logic  meta_full;
    logic  meta_empty;

    resp_t rsp_in;
    resp_t rsp_head;
    logic  rsp_push;
    logic  rsp_full;
    logic  rsp_empty;

    assign aligned = lsu_aligned(req_addr[2:0], req_size);
    assign rsp_pop = resp_valid & resp_ready;

    // credit counts in-flight loads plus buffered results;
    // a same-cycle consumer pop frees a slot immediately.
    assign slot_free = (credit < CW'(DEPTH)) | rsp_pop;
    assign idle      = (credit == '0);

    // Misaligned loads bypass memory, so they wait for an
    // empty unit to keep responses in order.
    assign req_ready = rst & (aligned ? (mem_req_ready & slot_free)
                                      : idle);

    assign mem_req_valid = rst & req_valid & aligned & slot_free;
    assign mem_addr      = {req_addr[AW-1:3], 3'b000};

    assign acc     = req_valid & req_ready;
    assign acc_al  = acc & aligned;
    assign acc_mis = acc & ~aligned;

    // Beats with nothing outstanding (e.g. after reset) are dropped.
    assign beat = mem_resp_valid & (inflight != '0);

    assign meta_in.offset = req_addr[2:0];
    assign meta_in.size   = req_size;
    assign meta_in.sgn    = req_signed;

    ysyx_040066_sync_fifo #(
        .WIDTH ($bits(meta_t)),
        .DEPTH (DEPTH)
    ) u_meta (
        .clk       (clk),
        .rst       (rst),
        .push      (acc_al),
        .push_data (meta_in),
        .pop       (beat),
        .full      (meta_full),
        .empty     (meta_empty),
        .head      (meta_head)
    );

    // Beat results and misaligned errors never coincide:
    // a misaligned accept needs inflight==0.
    always_comb begin
        rsp_in.data = '0;
        rsp_in.err  = 1'b1;
        if (beat) begin
            rsp_in.data = lsu_extract(mem_rdata, meta_head);
            rsp_in.err  = mem_resp_err;
        end
    end

    assign rsp_push = beat | acc_mis;

    ysyx_040066_sync_fifo #(
        .WIDTH ($bits(resp_t)),
        .DEPTH (DEPTH)
    ) u_resp (
        .clk       (clk),
        .rst       (rst),
        .push      (rsp_push),
        .push_data (rsp_in),
        .pop       (rsp_pop),
        .full      (rsp_full),
        .empty     (rsp_empty),
        .head      (rsp_head)
    );

    assign resp_valid = ~rsp_empty;
    assign resp_data  = rsp_empty ? 64'b0 : rsp_head.data;
    assign resp_err   = rsp_empty ? 1'b0  : rsp_head.err;

    always_ff @(posedge clk) begin
        if (!rst) begin
            credit   <= '0;
            inflight <= '0;
        end else begin
            credit   <= credit + CW'(acc) - CW'(rsp_pop);
            inflight <= inflight + CW'(acc_al) - CW'(beat);
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(mem_resp_valid && inflight == '0))
            else $warning("stray mem beat with no load in flight");
            assert (!(beat && meta_empty))
            else $error("meta fifo underflow");
            assert (!(acc_al && meta_full && !beat))
            else $error("meta fifo overflow");
            assert (!(rsp_push && rsp_full && !rsp_pop))
            else $error("resp buffer overflow");
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_040066_lsu_rd.sv
// Directed scoreboard bench for the load unit.
// Backing port and consumer are modelled inline in one process.
module tb_ysyx_040066_lsu_rd;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic        resp_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_addr;
    logic        mem_resp_valid;
    logic [63:0] mem_rdata;
    logic        mem_resp_err;
    logic        idle;

    ysyx_040066_lsu_rd #(.DEPTH(4), .AW(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_size       (req_size),
        .req_signed     (req_signed),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
        .resp_err       (resp_err),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata),
        .mem_resp_err   (mem_resp_err),
        .idle           (idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_chk  = 0;
    int          n_fail = 0;
    int          acc_cnt;
    logic        last_acc;
    logic        auto_resp;
    logic [63:0] err_addr;
    logic [63:0] pend [$];
    logic [64:0] exp_q [$];

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        if (a == 64'h8000_0000) return 64'h1122_3344_8566_7788;
        return {a[31:0] ^ 32'hDEAD_BEEF, ~a[31:0]};
    endfunction

    function automatic logic is_al(input logic [63:0] a, input logic [1:0] s);
        int n;
        n = 1 << s;
        return (int'(a[2:0]) % n) == 0;
    endfunction

    // Byte-wise gather, then sign fill above the field.
    function automatic logic [64:0] model(input logic [63:0] a,
                                          input logic [1:0] s,
                                          input logic sg);
        logic [63:0] b;
        logic [63:0] v;
        int          n;
        int          off;
        if (!is_al(a, s)) return {64'b0, 1'b1};
        b   = mem_word({a[63:3], 3'b000});
        n   = 1 << s;
        off = int'(a[2:0]);
        v   = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = b[8*(off+i) +: 8];
        if (sg && v[8*n-1])
            for (int k = 8*n; k < 64; k++) v[k] = 1'b1;
        return {v, ({a[63:3], 3'b000} == err_addr)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_chk++;
        n_fail++;
        $error("FAIL %s got=timeout exp=done", tag);
    endtask

    // One clock: drive beat, observe handshakes, cross the edge.
    task automatic step();
        logic [63:0] a;
        logic [64:0] e;
        if (auto_resp && pend.size() > 0) begin
            a = pend.pop_front();
            mem_resp_valid = 1'b1;
            mem_rdata      = mem_word(a);
            mem_resp_err   = (a == err_addr);
        end else begin
            mem_resp_valid = 1'b0;
            mem_rdata      = '0;
            mem_resp_err   = 1'b0;
        end
        #2;
        last_acc = 1'b0;
        if (!rst) exp_q.delete();
        if (req_valid && req_ready) begin
            last_acc = 1'b1;
            acc_cnt++;
            exp_q.push_back(model(req_addr, req_size, req_signed));
            if (!is_al(req_addr, req_size)) chk("mis_idle", 64'(idle), 64'd1);
        end
        if (mem_req_valid && mem_req_ready) pend.push_back(mem_addr);
        if (resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                timeout("unexpected_resp");
            end else begin
                e = exp_q.pop_front();
                chk("resp_data", resp_data, e[64:1]);
                chk("resp_err", 64'(resp_err), 64'(e[0]));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [63:0] a, input logic [1:0] s,
                         input logic sg);
        int k;
        req_addr   = a;
        req_size   = s;
        req_signed = sg;
        req_valid  = 1'b1;
        for (k = 0; k < 50; k++) begin
            step();
            if (last_acc) break;
        end
        req_valid = 1'b0;
        if (k == 50) timeout("issue");
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 100; k++) begin
            if (exp_q.size() == 0 && !resp_valid) break;
            step();
        end
        if (k == 100) timeout("drain");
    endtask

    initial begin
        int acc0;
        rst            = 1'b0;
        req_valid      = 1'b1;
        req_addr       = 64'h8000_0000;
        req_size       = 2'd3;
        req_signed     = 1'b0;
        resp_ready     = 1'b1;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
        mem_resp_err   = 1'b0;
        auto_resp      = 1'b0;
        err_addr       = 64'hFFFF_FFFF_FFFF_FFF8;
        acc_cnt        = 0;
        last_acc       = 1'b0;

        step();
        step();
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        chk("rst_idle", 64'(idle), 64'd1);
        req_valid = 1'b0;
        rst       = 1'b1;
        step();

        // LB signed: address alignment and one-cycle result latency
        auto_resp  = 1'b1;
        req_addr   = 64'h8000_0003;
        req_size   = 2'd0;
        req_signed = 1'b1;
        req_valid  = 1'b1;
        #1;
        chk("lb_mem_req_valid", 64'(mem_req_valid), 64'd1);
        chk("lb_mem_addr", mem_addr, 64'h8000_0000);
        issue(64'h8000_0003, 2'd0, 1'b1);
        chk("lb_no_early_resp", 64'(resp_valid), 64'd0);
        step();
        chk("lb_beat_seen", 64'(mem_resp_valid), 64'd1);
        chk("lb_resp_next_cycle", 64'(resp_valid), 64'd1);
        chk("lb_data_direct", resp_data, 64'hFFFF_FFFF_FFFF_FF85);
        drain();

        // Assorted sizes and modes on known beats
        issue(64'h8000_0004, 2'd2, 1'b0);
        issue(64'h8000_0008, 2'd3, 1'b0);
        issue(64'h8000_0006, 2'd1, 1'b1);
        issue(64'h8000_0003, 2'd0, 1'b0);
        issue(64'h8000_0000, 2'd2, 1'b1);
        issue(64'h8000_0012, 2'd1, 1'b1);
        drain();

        // Misaligned from idle: no beat, error next cycle
        req_addr   = 64'h8000_0001;
        req_size   = 2'd1;
        req_signed = 1'b0;
        req_valid  = 1'b1;
        #1;
        chk("mis_no_mem_req", 64'(mem_req_valid), 64'd0);
        chk("mis_ready_idle", 64'(req_ready), 64'd1);
        issue(64'h8000_0001, 2'd1, 1'b0);
        chk("mis_resp_next", 64'(resp_valid), 64'd1);
        chk("mis_resp_err", 64'(resp_err), 64'd1);
        drain();

        // Misaligned waits behind an in-flight load
        auto_resp = 1'b0;
        issue(64'h8000_0010, 2'd2, 1'b0);
        req_addr   = 64'h8000_0001;
        req_size   = 2'd1;
        req_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mis_blocked_ready", 64'(req_ready), 64'd0);
            chk("mis_blocked_mem", 64'(mem_req_valid), 64'd0);
        end
        auto_resp = 1'b1;
        issue(64'h8000_0001, 2'd1, 1'b0);
        drain();

        // Credit limit with a stalled consumer
        resp_ready = 1'b0;
        acc0       = acc_cnt;
        req_size   = 2'd3;
        req_signed = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req_addr  = 64'h8000_0040 + 64'(8 * (acc_cnt - acc0));
            req_valid = 1'b1;
            step();
        end
        for (int i = 0; i < 4; i++) step();
        chk("credit_accepts", 64'(acc_cnt - acc0), 64'd4);
        chk("credit_ready_low", 64'(req_ready), 64'd0);
        chk("credit_not_idle", 64'(idle), 64'd0);
        resp_ready = 1'b1;
        #1;
        chk("credit_pop_valid", 64'(resp_valid), 64'd1);
        chk("credit_ready_on_pop", 64'(req_ready), 64'd1);
        step();
        chk("credit_fifth_taken", 64'(last_acc), 64'd1);
        issue(64'h8000_0040 + 64'(8 * (acc_cnt - acc0)), 2'd3, 1'b0);
        drain();

        // Error on the middle of three loads
        err_addr = 64'h8000_0028;
        issue(64'h8000_0020, 2'd2, 1'b1);
        issue(64'h8000_002C, 2'd2, 1'b1);
        issue(64'h8000_0030, 2'd2, 1'b1);
        drain();
        err_addr = 64'hFFFF_FFFF_FFFF_FFF8;

        // Mid-operation reset, then stray beats
        auto_resp = 1'b0;
        issue(64'h8000_0000, 2'd3, 1'b0);
        issue(64'h8000_0008, 2'd3, 1'b0);
        chk("pre_rst_busy", 64'(idle), 64'd0);
        rst = 1'b0;
        step();
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        rst       = 1'b1;
        auto_resp = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stray_resp_valid", 64'(resp_valid), 64'd0);
            chk("stray_idle", 64'(idle), 64'd1);
        end
        chk("stray_no_expect", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
